// File: rtl/intersection_light_ctrl.sv
// Two-road (NS/EW) signal phase sequencer with a built-in 1-s prescaler and pedestrian walk.
// Define EMERGENCY_PREEMPT_EN to add emerg_req/emerg_dir green preemption.
module intersection_light_ctrl #(
  parameter int unsigned TICK_CYCLES = 50000000,
  parameter int unsigned GREEN_S     = 10,
  parameter int unsigned YELLOW_S    = 5,
  parameter int unsigned ALLRED_S    = 1,
  parameter int unsigned MIN_GREEN_S = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ped_req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emerg_req,
  input  logic       emerg_dir,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic       tick
);

  localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_ONE     = PRE_W'(1);
  localparam logic [7:0]       GREEN_LAST  = 8'(GREEN_S - 1);
  localparam logic [7:0]       YELLOW_LAST = 8'(YELLOW_S - 1);
  localparam logic [7:0]       ALLRED_LAST = 8'(ALLRED_S - 1);
  localparam logic [7:0]       MIN_LAST    = 8'(MIN_GREEN_S - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [PRE_W-1:0] pre_cnt_reg, pre_cnt_next;
  logic [7:0]       sec_cnt_reg, sec_cnt_next;
  logic             ped_pending_reg, ped_pending_next;
  logic             walk_en_reg, walk_en_next;

  logic [2:0]       ns_light_reg, ew_light_reg, phase_reg;
  logic             walk_reg, tick_reg;

  logic [7:0]       dur_last;
  logic             tick_now;
  logic             seconds_done;
  logic             ns_early_end;
  logic             walk_next;
  logic [2:0]       lamp_next [2];

  logic             preempt_ns, preempt_ew, preempt_active;

`ifdef EMERGENCY_PREEMPT_EN
  assign preempt_ns = emerg_req & ~emerg_dir;
  assign preempt_ew = emerg_req &  emerg_dir;
`else
  assign preempt_ns = 1'b0;
  assign preempt_ew = 1'b0;
`endif
  assign preempt_active = preempt_ns | preempt_ew;

  // Last seconds-count value of the current phase.
  always_comb begin
    dur_last = ALLRED_LAST;
    case (state_reg)
      NS_GREEN,  EW_GREEN:  dur_last = GREEN_LAST;
      NS_YELLOW, EW_YELLOW: dur_last = YELLOW_LAST;
      default:              dur_last = ALLRED_LAST;
    endcase
  end

  always_comb begin
    tick_now         = (pre_cnt_reg == PRE_LAST);
    pre_cnt_next     = tick_now ? '0 : pre_cnt_reg + PRE_ONE;
    sec_cnt_next     = tick_now ? sec_cnt_reg + 8'd1 : sec_cnt_reg;
    seconds_done     = tick_now && (sec_cnt_reg == dur_last);
    ns_early_end     = tick_now && ped_pending_reg && (sec_cnt_reg >= MIN_LAST);
    state_next       = state_reg;
    ped_pending_next = ped_pending_reg;
    walk_en_next     = walk_en_reg;

    case (state_reg)
      NS_GREEN: begin
        // Preemption beats both timers; a held green keeps its count at zero.
        if (preempt_ew)
          state_next = NS_YELLOW;
        else if (preempt_ns)
          sec_cnt_next = '0;
        else if (seconds_done || ns_early_end)
          state_next = NS_YELLOW;
      end
      NS_YELLOW: if (seconds_done) state_next = ALL_RED_1;
      ALL_RED_1: if (seconds_done) state_next = EW_GREEN;
      EW_GREEN: begin
        if (preempt_ns)
          state_next = EW_YELLOW;
        else if (preempt_ew)
          sec_cnt_next = '0;
        else if (seconds_done)
          state_next = EW_YELLOW;
      end
      EW_YELLOW: if (seconds_done) state_next = ALL_RED_2;
      ALL_RED_2: if (seconds_done) state_next = NS_GREEN;
      default:   state_next = ALL_RED_2;
    endcase

    if (state_next != state_reg)
      sec_cnt_next = '0;

    // Walk permission is decided once, on entry to EW green.
    if ((state_next == EW_GREEN) && (state_reg != EW_GREEN)) begin
      walk_en_next     = ped_pending_reg;
      ped_pending_next = 1'b0;
    end
    if (ped_req)
      ped_pending_next = 1'b1;

    walk_next = (state_next == EW_GREEN) && walk_en_next && !preempt_active;
  end

  // Lamp decode per road (0 = NS, 1 = EW) from the next state, so lamps are registered.
  for (genvar gi = 0; gi < 2; gi++) begin : g_road
    localparam logic [2:0] ROAD_GREEN  = (gi == 0) ? 3'd0 : 3'd3;
    localparam logic [2:0] ROAD_YELLOW = (gi == 0) ? 3'd1 : 3'd4;

    assign lamp_next[gi] = (state_next == ROAD_GREEN)  ? LAMP_GREEN  :
                           (state_next == ROAD_YELLOW) ? LAMP_YELLOW : LAMP_RED;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg       <= ALL_RED_2;
      pre_cnt_reg     <= '0;
      sec_cnt_reg     <= '0;
      ped_pending_reg <= 1'b0;
      walk_en_reg     <= 1'b0;
      ns_light_reg    <= LAMP_RED;
      ew_light_reg    <= LAMP_RED;
      walk_reg        <= 1'b0;
      phase_reg       <= 3'd5;
      tick_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pre_cnt_reg     <= pre_cnt_next;
      sec_cnt_reg     <= sec_cnt_next;
      ped_pending_reg <= ped_pending_next;
      walk_en_reg     <= walk_en_next;
      ns_light_reg    <= lamp_next[0];
      ew_light_reg    <= lamp_next[1];
      walk_reg        <= walk_next;
      phase_reg       <= state_next;
      tick_reg        <= (pre_cnt_next == PRE_LAST);
    end
  end

  assign ns_light = ns_light_reg;
  assign ew_light = ew_light_reg;
  assign walk     = walk_reg;
  assign phase    = phase_reg;
  assign tick     = tick_reg;

endmodule

// File: tb/tb_intersection_light_ctrl.sv
// Scoreboard bench for intersection_light_ctrl: expected phase segments {phase,length,walk}
// are queued by the stimulus and checked by a monitor as each phase ends.
module tb_intersection_light_ctrl;

  localparam int TICK = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       ped_req  = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
  logic       emerg_req = 1'b0;
  logic       emerg_dir = 1'b0;
`endif
  logic [2:0] ns_light, ew_light, phase;
  logic       walk, tick;

  typedef struct {
    int ph;
    int len;
    int wk;
  } seg_t;

  seg_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  intersection_light_ctrl #(
    .TICK_CYCLES (4),
    .GREEN_S     (10),
    .YELLOW_S    (5),
    .ALLRED_S    (1),
    .MIN_GREEN_S (3)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .ped_req   (ped_req),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req (emerg_req),
    .emerg_dir (emerg_dir),
`endif
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .walk      (walk),
    .phase     (phase),
    .tick      (tick)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_seg(input int ph, input int len, input int wk);
    seg_t s;
    s.ph  = ph;
    s.len = len;
    s.wk  = wk;
    sb.push_back(s);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK_50);
      #1;
      if (sb.size() == 0) return;
    end
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_phase(input int ph, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK_50);
      #1;
      if (int'(phase) == ph) return;
    end
    chk("wait_phase_timeout", int'(phase), ph);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ns"},    int'(ns_light), 4);
    chk({tag, "_ew"},    int'(ew_light), 4);
    chk({tag, "_walk"},  int'(walk),     0);
    chk({tag, "_tick"},  int'(tick),     0);
    chk({tag, "_phase"}, int'(phase),    5);
  endtask

  // Monitor: per-cycle lamp/walk/tick checks and segment scoreboard.
  initial begin
    int   cur_phase = 5;
    int   run_len   = 0;
    int   tick_gap  = 0;
    bit   walk_hi   = 0;
    bit   walk_lo   = 0;
    int   exp_ns, exp_ew, seg_wk;
    seg_t e;
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        cur_phase = 5;
        run_len   = 0;
        tick_gap  = 0;
        walk_hi   = 0;
        walk_lo   = 0;
      end else begin
        if (int'(phase) != cur_phase) begin
          seg_wk = (walk_hi && walk_lo) ? 2 : int'(walk_hi);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("segment phase=%0d len=%0d walk=%0d (expect phase=%0d len=%0d walk=%0d)",
                     cur_phase, run_len, seg_wk, e.ph, e.len, e.wk);
            chk("seg_phase", cur_phase, e.ph);
            chk("seg_len",   run_len,   e.len);
            chk("seg_walk",  seg_wk,    e.wk);
          end
          cur_phase = int'(phase);
          run_len   = 0;
          walk_hi   = 0;
          walk_lo   = 0;
        end
        run_len++;
        if (walk) walk_hi = 1;
        else      walk_lo = 1;

        tick_gap++;
        if (tick) begin
          chk("tick_gap", tick_gap, TICK);
          tick_gap = 0;
        end

        exp_ns = (phase == 3'd0) ? 1 : (phase == 3'd1) ? 2 : 4;
        exp_ew = (phase == 3'd3) ? 1 : (phase == 3'd4) ? 2 : 4;
        chk("ns_lamp", int'(ns_light), exp_ns);
        chk("ew_lamp", int'(ew_light), exp_ew);
        chk("both_not_red", int'((ns_light != 3'b100) && (ew_light != 3'b100)), 0);
        if (phase != 3'd3)
          chk("walk_outside_ew", int'(walk), 0);
      end
    end
  end

  // Stimulus
  initial begin
    // Reset held two cycles, then free run through a full cycle.
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check_reset_state("rst1");
    @(posedge CLOCK_50);
    #1;
    check_reset_state("rst2");
    push_seg(5, 4, 0);
    push_seg(0, 40, 0);
    push_seg(1, 20, 0);
    push_seg(2, 4, 0);
    push_seg(3, 40, 0);
    push_seg(4, 20, 0);
    push_seg(5, 4, 0);
    reset = 1'b0;
    wait_drain(300);

    // Now at first cycle of NS_GREEN: ped pulse at second 1 shortens green, grants walk.
    push_seg(0, 12, 0);
    push_seg(1, 20, 0);
    push_seg(2, 4, 0);
    push_seg(3, 40, 1);
    push_seg(4, 20, 0);
    push_seg(5, 4, 0);
    push_seg(0, 40, 0);
    repeat (5) @(negedge CLOCK_50);
    ped_req = 1'b1;
    @(negedge CLOCK_50);
    ped_req = 1'b0;
    wait_drain(300);

    // Now at first cycle of NS_YELLOW: ped request during an EW green without walk.
    push_seg(1, 20, 0);
    push_seg(2, 4, 0);
    push_seg(3, 40, 0);
    push_seg(4, 20, 0);
    push_seg(5, 4, 0);
    push_seg(0, 12, 0);
    push_seg(1, 20, 0);
    push_seg(2, 4, 0);
    push_seg(3, 40, 1);
    wait_phase(3, 60);
    repeat (5) @(negedge CLOCK_50);
    ped_req = 1'b1;
    @(negedge CLOCK_50);
    ped_req = 1'b0;
    wait_drain(300);

    // Now in EW_YELLOW: pending ped request, then reset mid-phase clears everything.
    @(negedge CLOCK_50);
    ped_req = 1'b1;
    @(negedge CLOCK_50);
    ped_req = 1'b0;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check_reset_state("rst_mid");
    push_seg(5, 4, 0);
    push_seg(0, 40, 0);
    reset = 1'b0;
    wait_drain(100);

`ifdef EMERGENCY_PREEMPT_EN
    // EW preemption raised on the tick at NS_GREEN second 2, held 12 cycles into EW green.
    wait_phase(0, 200);
    push_seg(0, 12, 0);
    push_seg(1, 20, 0);
    push_seg(2, 4, 0);
    push_seg(3, 52, 0);
    push_seg(4, 20, 0);
    push_seg(5, 4, 0);
    repeat (11) @(negedge CLOCK_50);
    emerg_dir = 1'b1;
    emerg_req = 1'b1;
    wait_phase(3, 100);
    repeat (12) @(negedge CLOCK_50);
    emerg_req = 1'b0;
    wait_drain(300);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "simulation time limit reached");
  end

endmodule
